// File: rtl/alu_seq_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_seq_core.sv
// Combinational datapath for all single-cycle ALU operations.
// MUL is not handled here and yields result 0 with clear flags.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic             sub_c;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;

    // Shared adder: SUB is x + ~b + 1
    always_comb begin
        sub_c   = (op == OP_SUB);
        b_eff   = sub_c ? ~b : b;
        sum_ext = {1'b0, x} + {1'b0, b_eff} + (WIDTH+1)'(sub_c);
    end

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                result   = sum_ext[WIDTH-1:0];
                carry    = sum_ext[WIDTH];
                overflow = (x[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (sum_ext[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND: result = x & b;
            OP_OR:  result = x | b;
            OP_XOR: result = x ^ b;
            OP_NOT: result = ~x;
            OP_SHL: begin
                result = {x[WIDTH-2:0], 1'b0};
                carry  = x[WIDTH-1];
            end
            default: begin
                result   = '0;
                carry    = 1'b0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: registered result/flags, single-cycle ops plus an iterative
// shift-add multiplier enabled by macro ALU_SEQ_MUL_EN (else MUL returns 0).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             acc_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             zero,
    output logic             carry,
    output logic             sign,
    output logic             overflow
);

    logic [WIDTH-1:0] r_q, r_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             sign_q, sign_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] x_c;
    logic [WIDTH-1:0] core_res;
    logic             core_carry;
    logic             core_ovf;

    assign x_c = acc_sel ? r_q : a;

    alu_seq_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x        (x_c),
        .b        (b),
        .op       (op),
        .result   (core_res),
        .carry    (core_carry),
        .overflow (core_ovf)
    );

`ifdef ALU_SEQ_MUL_EN
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [2*WIDTH-1:0]   step_c;
    logic [WIDTH:0]       psum_c;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && (op == OP_MUL)) state_d = S_MUL;
            S_MUL:   if (cnt_q == CNT_W'(1))     state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One shift-add step: upper half accumulates multiplicand, whole product shifts right
    always_comb begin
        psum_c = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        step_c = prod_q[0] ? {psum_c, prod_q[WIDTH-1:1]}
                           : {1'b0, prod_q[2*WIDTH-1:1]};
    end

    always_comb begin
        r_d     = r_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mcand_d = x_c;
                        prod_d  = {{WIDTH{1'b0}}, b};
                        cnt_d   = CNT_W'(WIDTH);
                        busy_d  = 1'b1;
                    end else begin
                        r_d     = core_res;
                        carry_d = core_carry;
                        ovf_d   = core_ovf;
                        done_d  = 1'b1;
                    end
                end
            end
            S_MUL: begin
                prod_d = step_c;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    r_d     = step_c[WIDTH-1:0];
                    carry_d = |step_c[2*WIDTH-1:WIDTH];
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
        zero_d = (r_d == '0);
        sign_d = r_d[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    // Every op completes in one cycle; MUL comes out of the core as zero
    always_comb begin
        r_d     = r_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
            r_d     = core_res;
            carry_d = core_carry;
            ovf_d   = core_ovf;
            done_d  = 1'b1;
        end
        zero_d = (r_d == '0);
        sign_d = r_d[WIDTH-1];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q     <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            r_q     <= r_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign r        = r_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign sign     = sign_q;
    assign overflow = ovf_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed cases followed by random traffic.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 8;
    localparam longint MASK = (64'd1 << W) - 1;
    localparam longint HALF = 64'd1 << (W - 1);

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic         acc_sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] r;
    logic         zero;
    logic         carry;
    logic         sign;
    logic         overflow;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .acc_sel  (acc_sel),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .r        (r),
        .zero     (zero),
        .carry    (carry),
        .sign     (sign),
        .overflow (overflow)
    );

    typedef struct {
        int     due;
        bit     exp_done;
        longint r;
        bit     z;
        bit     c;
        bit     s;
        bit     v;
    } exp_t;

    exp_t   sbq[$];
    int     checks   = 0;
    int     failures = 0;
    int     edge_cnt = 0;
    bit     mon_en   = 1'b0;
    bit     exp_busy = 1'b0;
    longint model_r  = 0;
    int     busy_left = 0;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_cnt, act, exp);
        end
    endtask

    function automatic longint sgn(input longint v);
        return (v >= HALF) ? v - (64'd1 << W) : v;
    endfunction

    // Reference behaviour from the arithmetic definition of each opcode
    function automatic exp_t model_op(input logic [2:0] o, input longint x, input longint bv);
        exp_t   e;
        longint s;
        longint sv;
        e.due = 0; e.exp_done = 1'b1; e.r = 0; e.c = 1'b0; e.v = 1'b0;
        case (o)
            OP_ADD: begin
                s   = x + bv;
                e.r = s & MASK;
                e.c = ((s >> W) & 1) != 0;
                sv  = sgn(x) + sgn(bv);
                e.v = (sv < -HALF) || (sv > HALF - 1);
            end
            OP_SUB: begin
                s   = x + ((~bv) & MASK) + 1;
                e.r = s & MASK;
                e.c = ((s >> W) & 1) != 0;
                sv  = sgn(x) - sgn(bv);
                e.v = (sv < -HALF) || (sv > HALF - 1);
            end
            OP_AND: e.r = x & bv;
            OP_OR:  e.r = x | bv;
            OP_XOR: e.r = x ^ bv;
            OP_NOT: e.r = (~x) & MASK;
            OP_SHL: begin
                e.r = (x << 1) & MASK;
                e.c = ((x >> (W - 1)) & 1) != 0;
            end
            default: begin
                if (MUL_EN) begin
                    s   = x * bv;
                    e.r = s & MASK;
                    e.c = (s >> W) != 0;
                end
            end
        endcase
        e.z = (e.r == 0);
        e.s = ((e.r >> (W - 1)) & 1) != 0;
        return e;
    endfunction

    // Drive one cycle, then advance the model by the edge that sampled it
    task automatic step(input bit rs, input bit st, input logic [2:0] o, input bit ac,
                        input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t   e;
        longint x;
        bit     is_mul;
        reset = rs; start = st; op = o; acc_sel = ac; a = av; b = bv;
        @(posedge clk);
        #1;
        if (rs) begin
            busy_left = 0;
            model_r   = 0;
            sbq.delete();
            e.due = edge_cnt; e.exp_done = 1'b0; e.r = 0;
            e.z = 1'b1; e.c = 1'b0; e.s = 1'b0; e.v = 1'b0;
            sbq.push_back(e);
            mon_en = 1'b1;
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (st) begin
            x      = ac ? model_r : longint'(av);
            e      = model_op(o, x, longint'(bv));
            is_mul = MUL_EN && (o == OP_MUL);
            e.due  = edge_cnt + (is_mul ? W : 0);
            sbq.push_back(e);
            model_r = e.r;
            if (is_mul) busy_left = W;
        end
        exp_busy = (busy_left > 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 3'($urandom), 1'($urandom), W'($urandom), W'($urandom));
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("busy", longint'(busy), longint'(exp_busy));
            if (sbq.size() > 0 && sbq[0].due < edge_cnt) begin
                e = sbq.pop_front();
                chk("missed_expectation", 0, 1);
            end
            if (sbq.size() > 0 && sbq[0].due == edge_cnt) begin
                e = sbq.pop_front();
                chk("done", longint'(done), longint'(e.exp_done));
                chk("r", longint'(r), e.r);
                chk("zero", longint'(zero), longint'(e.z));
                chk("carry", longint'(carry), longint'(e.c));
                chk("sign", longint'(sign), longint'(e.s));
                chk("overflow", longint'(overflow), longint'(e.v));
            end else begin
                chk("done_idle", longint'(done), 0);
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; acc_sel = 1'b0; a = '0; b = '0;
        step(1'b1, 1'b0, OP_ADD, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b1, OP_ADD, 1'b0, 8'h12, 8'h34);
        idle(1);
        step(1'b0, 1'b1, OP_ADD, 1'b0, 8'hFF, 8'h01);
        idle(1);
        step(1'b0, 1'b1, OP_SUB, 1'b0, 8'h80, 8'h01);
        step(1'b0, 1'b1, OP_SUB, 1'b1, 8'h00, 8'h80);
        idle(1);
        step(1'b0, 1'b1, OP_MUL, 1'b0, 8'h0F, 8'h11);
        idle(W + 1);
        step(1'b0, 1'b1, OP_MUL, 1'b0, 8'h10, 8'h10);
        idle(W + 1);
        // Start during a busy MUL must be ignored
        step(1'b0, 1'b1, OP_MUL, 1'b0, 8'h03, 8'h05);
        step(1'b0, 1'b1, OP_ADD, 1'b0, 8'h01, 8'h01);
        idle(W);
        // Reset on the fourth MUL cycle aborts it
        step(1'b0, 1'b1, OP_MUL, 1'b0, 8'h07, 8'h09);
        idle(3);
        step(1'b1, 1'b0, OP_ADD, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b1, OP_ADD, 1'b0, 8'h02, 8'h03);
        step(1'b0, 1'b1, OP_MUL, 1'b1, 8'h00, 8'h03);
        idle(W + 1);
        step(1'b0, 1'b1, OP_SHL, 1'b0, 8'hC1, 8'h00);
        step(1'b0, 1'b1, OP_NOT, 1'b1, 8'h00, 8'h00);
        step(1'b0, 1'b1, OP_XOR, 1'b0, 8'hA5, 8'hA5);
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 9) < 6),
                 3'($urandom), 1'($urandom), W'($urandom), W'($urandom));
        end
        idle(W + 2);
        chk("scoreboard_drained", longint'(sbq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
